// File: rtl/win_tile_sched.sv
// Winograd F(2x2,3x3) input-transform tile scheduler.
// Walks the feature map tile by tile (tile_x inner, tile_y outer). For each
// tile it reads four SRAM rows, kicks the transform, captures its result and
// offers it downstream over a valid/ready handshake.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for start, cfg latched on start
// S_RD     | four SRAM reads, one row per cycle, ascending row order
// S_DRAIN  | last read word arrives and is captured
// S_KICK   | tf_enable pulse
// S_WAIT   | waiting for tf_end, bounded by the timeout down-counter
// S_CAP    | transform outputs valid this cycle, registered into out_data
// S_OUT    | out_valid held until accepted
// S_FIN    | done pulse, then back to idle
module win_tile_sched #(
  parameter int ADDR_W  = 12,
  parameter int DIM_W   = 6,
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        cfg_bitwidth,
  input  logic [DIM_W-1:0]  cfg_tiles_x,
  input  logic [DIM_W-1:0]  cfg_tiles_y,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_row_stride,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [63:0]       rd_data,
  output logic              tf_enable,
  output logic [1:0]        tf_bitwidth,
  output logic [63:0]       tf_act1,
  output logic [63:0]       tf_act2,
  output logic [63:0]       tf_act3,
  output logic [63:0]       tf_act4,
  input  logic              tf_end,
  input  logic [63:0]       tf_v1,
  input  logic [63:0]       tf_v2,
  input  logic [63:0]       tf_v3,
  input  logic [63:0]       tf_v4,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [255:0]      out_data,
  output logic [DIM_W-1:0]  out_tx,
  output logic [DIM_W-1:0]  out_ty,
  output logic              out_last
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_DRAIN, S_KICK, S_WAIT, S_CAP, S_OUT, S_FIN
  } state_t;

  state_t            state;
  logic [1:0]        rd_cnt;
  logic [TMR_W-1:0]  timer;
  logic [DIM_W-1:0]  tx;
  logic [DIM_W-1:0]  ty;
  logic [DIM_W-1:0]  tiles_x;
  logic [DIM_W-1:0]  tiles_y;
  logic [ADDR_W-1:0] stride;
  logic [ADDR_W-1:0] line_addr;   // address of row 2*ty, tile column 0

  logic              last_x;
  logic              last_tile;
  logic [ADDR_W-1:0] line_next;
  logic [ADDR_W-1:0] col_next;

  assign last_x    = (tx == tiles_x - DIM_W'(1));
  assign last_tile = last_x && (ty == tiles_y - DIM_W'(1));
  // Consecutive tile rows overlap by two feature-map rows.
  assign line_next = line_addr + (stride << 1);
  assign col_next  = line_addr + ADDR_W'(tx) + ADDR_W'(1);

  // Sequencer: state, counters and every registered output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      rd_cnt      <= '0;
      timer       <= '0;
      tx          <= '0;
      ty          <= '0;
      tiles_x     <= '0;
      tiles_y     <= '0;
      stride      <= '0;
      line_addr   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      tf_enable   <= 1'b0;
      tf_bitwidth <= '0;
      tf_act1     <= '0;
      tf_act2     <= '0;
      tf_act3     <= '0;
      tf_act4     <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_tx      <= '0;
      out_ty      <= '0;
      out_last    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            tiles_x     <= cfg_tiles_x;
            tiles_y     <= cfg_tiles_y;
            stride      <= cfg_row_stride;
            line_addr   <= cfg_base;
            tf_bitwidth <= cfg_bitwidth;
            err         <= 1'b0;
            tx          <= '0;
            ty          <= '0;
            if (cfg_tiles_x == '0 || cfg_tiles_y == '0) begin
              done  <= 1'b1;
              state <= S_FIN;
            end else begin
              busy    <= 1'b1;
              rd_en   <= 1'b1;
              rd_addr <= cfg_base;
              rd_cnt  <= '0;
              state   <= S_RD;
            end
          end
        end
        S_RD: begin
          // Read data trails the strobe by one cycle: word for row n lands
          // while the strobe for row n+1 is out.
          case (rd_cnt)
            2'd1:    tf_act4 <= rd_data;
            2'd2:    tf_act3 <= rd_data;
            2'd3:    tf_act2 <= rd_data;
            default: ;
          endcase
          if (rd_cnt == 2'd3) begin
            rd_en <= 1'b0;
            state <= S_DRAIN;
          end else begin
            rd_addr <= rd_addr + stride;
            rd_cnt  <= rd_cnt + 2'd1;
          end
        end
        S_DRAIN: begin
          tf_act1   <= rd_data;
          tf_enable <= 1'b1;
          state     <= S_KICK;
        end
        S_KICK: begin
          tf_enable <= 1'b0;
          timer     <= TMR_W'(TIMEOUT - 1);
          state     <= S_WAIT;
        end
        S_WAIT: begin
          if (tf_end) begin
            state <= S_CAP;
          end else if (timer == '0) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_FIN;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        S_CAP: begin
          out_data  <= {tf_v1, tf_v2, tf_v3, tf_v4};
          out_tx    <= tx;
          out_ty    <= ty;
          out_last  <= last_tile;
          out_valid <= 1'b1;
          state     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (last_tile) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_FIN;
            end else begin
              if (last_x) begin
                tx        <= '0;
                ty        <= ty + DIM_W'(1);
                line_addr <= line_next;
                rd_addr   <= line_next;
              end else begin
                tx      <= tx + DIM_W'(1);
                rd_addr <= col_next;
              end
              rd_en  <= 1'b1;
              rd_cnt <= '0;
              state  <= S_RD;
            end
          end
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_win_tile_sched.sv
// Self-checking bench for win_tile_sched. The bench plays the SRAM and the
// transform, predicts the read sequence and emitted tiles from the address
// rules, and compares against the DUT every cycle on the falling edge.
module tb_win_tile_sched;

  localparam int ADDR_W  = 12;
  localparam int DIM_W   = 6;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [1:0]        cfg_bitwidth;
  logic [DIM_W-1:0]  cfg_tiles_x;
  logic [DIM_W-1:0]  cfg_tiles_y;
  logic [ADDR_W-1:0] cfg_base;
  logic [ADDR_W-1:0] cfg_row_stride;
  logic              busy, done, err;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [63:0]       rd_data;
  logic              tf_enable;
  logic [1:0]        tf_bitwidth;
  logic [63:0]       tf_act1, tf_act2, tf_act3, tf_act4;
  logic              tf_end;
  logic [63:0]       tf_v1, tf_v2, tf_v3, tf_v4;
  logic              out_valid;
  logic              out_ready;
  logic [255:0]      out_data;
  logic [DIM_W-1:0]  out_tx, out_ty;
  logic              out_last;

  always #5 clk = ~clk;

  win_tile_sched #(.ADDR_W(ADDR_W), .DIM_W(DIM_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_bitwidth(cfg_bitwidth), .cfg_tiles_x(cfg_tiles_x), .cfg_tiles_y(cfg_tiles_y),
    .cfg_base(cfg_base), .cfg_row_stride(cfg_row_stride),
    .busy(busy), .done(done), .err(err),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .tf_enable(tf_enable), .tf_bitwidth(tf_bitwidth),
    .tf_act1(tf_act1), .tf_act2(tf_act2), .tf_act3(tf_act3), .tf_act4(tf_act4),
    .tf_end(tf_end), .tf_v1(tf_v1), .tf_v2(tf_v2), .tf_v3(tf_v3), .tf_v4(tf_v4),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tx(out_tx), .out_ty(out_ty), .out_last(out_last)
  );

  typedef struct packed {
    logic [DIM_W-1:0] tx;
    logic [DIM_W-1:0] ty;
    logic             last;
    logic [3:0][63:0] w;
    logic [255:0]     data;
  } tile_t;

  logic [63:0]       mem [0:4095];
  logic [ADDR_W-1:0] exp_rd[$];
  tile_t             exp_tiles[$];

  int n_checks = 0;
  int n_fail   = 0;

  // SRAM / transform / downstream model state
  logic              rd_pend;
  logic [ADDR_W-1:0] rd_pend_addr;
  logic [2:0]        tf_hist;
  logic [255:0]      tf_res;
  bit                tf_dead;
  logic [1:0]        cur_mode;
  int                ready_mode;
  int                stall_left;
  bit                prev_stall;
  logic [255:0]      prev_data;
  logic [2*DIM_W:0]  prev_meta;
  bit                err_exp;

  // per-job observations
  int cyc, first_rd, first_tfen, first_ov, done_cyc, done_cnt;
  int hs_cnt, rd_cnt_job, tfen_cnt, ov_cnt, last_hs_cyc;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Winograd input transform V = B^T d B on 16-bit lanes, d rows r0..r3.
  function automatic logic [255:0] wino(input logic [63:0] r0, input logic [63:0] r1,
                                        input logic [63:0] r2, input logic [63:0] r3);
    logic [15:0] d [4][4];
    logic [15:0] t [4][4];
    logic [15:0] v [4][4];
    logic [255:0] res;
    for (int j = 0; j < 4; j++) begin
      d[0][j] = r0[16*j +: 16];
      d[1][j] = r1[16*j +: 16];
      d[2][j] = r2[16*j +: 16];
      d[3][j] = r3[16*j +: 16];
    end
    for (int j = 0; j < 4; j++) begin
      t[0][j] = d[0][j] - d[2][j];
      t[1][j] = d[1][j] + d[2][j];
      t[2][j] = d[2][j] - d[1][j];
      t[3][j] = d[1][j] - d[3][j];
    end
    for (int i = 0; i < 4; i++) begin
      v[i][0] = t[i][0] - t[i][2];
      v[i][1] = t[i][1] + t[i][2];
      v[i][2] = t[i][2] - t[i][1];
      v[i][3] = t[i][1] - t[i][3];
    end
    for (int i = 0; i < 4; i++)
      res[255-64*i -: 64] = {v[i][3], v[i][2], v[i][1], v[i][0]};
    return res;
  endfunction

  task automatic build_job(input int nx, input int ny, input int base, input int stride);
    tile_t t;
    for (int ty = 0; ty < ny; ty++) begin
      for (int tx = 0; tx < nx; tx++) begin
        for (int r = 0; r < 4; r++) begin
          int a;
          logic [ADDR_W-1:0] ad;
          a  = base + (2*ty + r) * stride + tx;
          ad = a[ADDR_W-1:0];
          exp_rd.push_back(ad);
          t.w[r] = mem[ad];
        end
        t.tx   = DIM_W'(tx);
        t.ty   = DIM_W'(ty);
        t.last = (tx == nx - 1) && (ty == ny - 1);
        t.data = wino(t.w[0], t.w[1], t.w[2], t.w[3]);
        exp_tiles.push_back(t);
      end
    end
  endtask

  task automatic clear_stats();
    first_rd = -1; first_tfen = -1; first_ov = -1; done_cyc = -1;
    done_cnt = 0; hs_cnt = 0; rd_cnt_job = 0; tfen_cnt = 0; ov_cnt = 0;
    last_hs_cyc = -100; prev_stall = 0;
  endtask

  // One clock: observe DUT outputs mid-cycle and drive this cycle's inputs.
  task automatic step();
    logic r;
    tile_t t;
    @(negedge clk);
    cyc++;
    rd_data = rd_pend ? mem[rd_pend_addr] : {$urandom, $urandom};
    if (rd_en) begin
      if (rd_cnt_job > 0 && rd_cnt_job % 4 == 0)
        check_val("next_tile_first_rd", 256'(cyc), 256'(last_hs_cyc + 1));
      if (exp_rd.size() > 0) check_val("rd_addr", 256'(rd_addr), 256'(exp_rd.pop_front()));
      else check_val("unexpected_rd_en", 256'(rd_en), 256'(0));
      if (first_rd < 0) first_rd = cyc;
      rd_cnt_job++;
    end
    rd_pend      = rd_en;
    rd_pend_addr = rd_addr;

    tf_end = tf_hist[1] && !tf_dead;
    if (tf_hist[2] && !tf_dead) {tf_v1, tf_v2, tf_v3, tf_v4} = tf_res;
    else {tf_v1, tf_v2, tf_v3, tf_v4} = {8{$urandom}};
    if (tf_enable) begin
      if (first_tfen < 0) first_tfen = cyc;
      tfen_cnt++;
      check_val("tf_bitwidth", 256'(tf_bitwidth), 256'(cur_mode));
      if (exp_tiles.size() > 0) begin
        t = exp_tiles[0];
        check_val("tf_act4", 256'(tf_act4), 256'(t.w[0]));
        check_val("tf_act3", 256'(tf_act3), 256'(t.w[1]));
        check_val("tf_act2", 256'(tf_act2), 256'(t.w[2]));
        check_val("tf_act1", 256'(tf_act1), 256'(t.w[3]));
      end else begin
        check_val("unexpected_tf_enable", 256'(tf_enable), 256'(0));
      end
      tf_res = wino(tf_act4, tf_act3, tf_act2, tf_act1);
    end
    tf_hist = {tf_hist[1:0], tf_enable};

    if (out_valid) begin
      if (first_ov < 0) first_ov = cyc;
      ov_cnt++;
      check_val("rd_en_while_out_valid", 256'(rd_en), 256'(0));
      if (prev_stall) begin
        check_val("stall_data_stable", out_data, prev_data);
        check_val("stall_meta_stable", 256'({out_last, out_ty, out_tx}), 256'(prev_meta));
      end
      if (ready_mode == 0) r = 1'b1;
      else if (ready_mode == 1) r = 1'($urandom_range(0, 1));
      else if (stall_left > 0 && hs_cnt == 0) begin
        r = 1'b0;
        stall_left--;
      end else r = 1'b1;
      out_ready = r;
      if (r) begin
        hs_cnt++;
        last_hs_cyc = cyc;
        prev_stall  = 0;
        if (exp_tiles.size() > 0) begin
          t = exp_tiles.pop_front();
          check_val("out_data", out_data, t.data);
          check_val("out_tx", 256'(out_tx), 256'(t.tx));
          check_val("out_ty", 256'(out_ty), 256'(t.ty));
          check_val("out_last", 256'(out_last), 256'(t.last));
        end else begin
          check_val("unexpected_tile", 256'(out_valid), 256'(0));
        end
      end else begin
        prev_stall = 1;
        prev_data  = out_data;
        prev_meta  = {out_last, out_ty, out_tx};
      end
    end else begin
      out_ready  = 1'($urandom_range(0, 1));
      prev_stall = 0;
    end

    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic drive_cfg(input int nx, input int ny, input int base, input int stride,
                           input int mode);
    cfg_tiles_x    = DIM_W'(nx);
    cfg_tiles_y    = DIM_W'(ny);
    cfg_base       = ADDR_W'(base);
    cfg_row_stride = ADDR_W'(stride);
    cfg_bitwidth   = 2'(mode);
  endtask

  task automatic run_job(input int nx, input int ny, input int base, input int stride,
                         input int mode, input int rmode, input bit timeout);
    bit zero;
    zero = (nx == 0) || (ny == 0);
    clear_stats();
    exp_rd.delete();
    exp_tiles.delete();
    if (!zero) build_job(nx, ny, base, stride);
    cur_mode   = 2'(mode);
    ready_mode = rmode;
    stall_left = (rmode == 2) ? 5 : 0;
    tf_dead    = timeout;
    check_val("err_before_start", 256'(err), 256'(err_exp));
    drive_cfg(nx, ny, base, stride, mode);
    start = 1'b1;
    cyc   = 0;
    for (int b = 0; b < 3000 && done_cnt == 0; b++) begin
      step();
      if (cyc == 1) begin
        start = 1'b0;
        check_val("busy_after_start", 256'(busy), 256'(!zero));
        check_val("err_cleared_by_start", 256'(err), 256'(0));
      end
      if (cyc == 3 && !zero) start = 1'b1;
      if (cyc == 4) start = 1'b0;
      drive_cfg($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 4095),
                $urandom_range(0, 4095), $urandom_range(0, 3));
      if (done) begin
        check_val("busy_at_done", 256'(busy), 256'(0));
        check_val("err_at_done", 256'(err), 256'(timeout));
      end
    end
    start = 1'b0;
    repeat (3) step();
    check_val("single_done", 256'(done_cnt), 256'(1));
    if (zero) begin
      check_val("zero_done_cycle", 256'(done_cyc), 256'(1));
      check_val("zero_no_rd", 256'(rd_cnt_job), 256'(0));
      check_val("zero_no_tf_enable", 256'(tfen_cnt), 256'(0));
    end else if (timeout) begin
      check_val("to_first_rd", 256'(first_rd), 256'(1));
      check_val("to_tf_enable", 256'(first_tfen), 256'(6));
      check_val("to_done_cycle", 256'(done_cyc), 256'(6 + 1 + TIMEOUT));
      check_val("to_no_tile", 256'(ov_cnt), 256'(0));
    end else begin
      check_val("first_rd_cycle", 256'(first_rd), 256'(1));
      check_val("first_tf_enable_cycle", 256'(first_tfen), 256'(6));
      check_val("first_out_valid_cycle", 256'(first_ov), 256'(10));
      check_val("tiles_emitted", 256'(hs_cnt), 256'(nx * ny));
      check_val("done_after_last_hs", 256'(done_cyc), 256'(last_hs_cyc + 1));
      check_val("reads_left", 256'(exp_rd.size()), 256'(0));
      check_val("tiles_left", 256'(exp_tiles.size()), 256'(0));
    end
    err_exp = timeout;
    tf_dead = 0;
    exp_rd.delete();
    exp_tiles.delete();
  endtask

  task automatic rst_mid_job();
    clear_stats();
    exp_rd.delete();
    exp_tiles.delete();
    build_job(3, 1, 'h400, 12);
    cur_mode   = 2'd2;
    ready_mode = 0;
    drive_cfg(3, 1, 'h400, 12, 2);
    start = 1'b1;
    cyc   = 0;
    for (int b = 0; b < 500; b++) begin
      step();
      if (cyc == 1) start = 1'b0;
      if (tf_enable && hs_cnt == 2) break;
    end
    check_val("rst_reached_tile2", 256'(hs_cnt), 256'(2));
    step();
    rst = 1'b1;
    step();
    check_val("rst_ctrl_outputs", 256'({busy, done, err, rd_en, rd_addr, tf_enable, tf_bitwidth,
              out_valid, out_tx, out_ty, out_last}), 256'(0));
    check_val("rst_acts", 256'(tf_act1 | tf_act2 | tf_act3 | tf_act4), 256'(0));
    check_val("rst_out_data", out_data, 256'(0));
    rst = 1'b0;
    exp_rd.delete();
    exp_tiles.delete();
    tf_hist = '0;
    rd_pend = 1'b0;
    done_cnt = 0;
    repeat (5) step();
    check_val("no_done_after_rst", 256'(done_cnt), 256'(0));
    err_exp = 0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = {$urandom, $urandom};
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; tf_end = 1'b0;
    rd_data = '0; {tf_v1, tf_v2, tf_v3, tf_v4} = '0;
    drive_cfg(0, 0, 0, 0, 0);
    rd_pend = 0; tf_hist = '0; tf_res = '0; tf_dead = 0; cur_mode = '0;
    ready_mode = 0; stall_left = 0; prev_data = '0; prev_meta = '0; err_exp = 0;
    cyc = 0;
    clear_stats();
    repeat (3) step();
    check_val("reset_ctrl_outputs", 256'({busy, done, err, rd_en, rd_addr, tf_enable, tf_bitwidth,
              out_valid, out_tx, out_ty, out_last}), 256'(0));
    check_val("reset_acts", 256'(tf_act1 | tf_act2 | tf_act3 | tf_act4), 256'(0));
    check_val("reset_out_data", out_data, 256'(0));
    rst = 1'b0;
    step();

    // single tile, distinct lane values
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 4; j++)
        mem['h010 + 4*r][16*j +: 16] = 16'(r * 64 + j * 7 + 3);
    run_job(1, 1, 'h010, 4, 0, 0, 0);
    // 3x2 job, 8x8 mode
    run_job(3, 2, 'h100, 10, 3, 0, 0);
    // back-pressure on tile 0
    run_job(2, 1, 'h200, 8, 1, 2, 0);
    // transform never finishes
    run_job(1, 1, 'h300, 4, 2, 0, 1);
    // zero-size job right after the timeout (also clears err)
    run_job(0, 2, 'h050, 4, 0, 0, 0);
    // reset mid-job, then a fresh job
    rst_mid_job();
    run_job(2, 1, 'h500, 6, 1, 0, 0);
    // randomized jobs, including address wrap-around
    for (int k = 0; k < 6; k++)
      run_job($urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(0, 4095),
              $urandom_range(1, 64), $urandom_range(0, 3), 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
